// File: rtl/clkgen_decoder_3_8.sv
// ---------------------------------------------------------------------------
// clkgen_decoder_3_8
//
// Combined utility block with two independent halves:
//   * a 3-to-8 one-hot decoder with active-high enable. The decoder has a
//     combinational output and a copy registered on clka.
//   * a clock unit. It forwards clka and samples the half-rate companion
//     clock clkb as ordinary data in the clka domain. From the sampled value
//     it produces one-cycle rise/fall pulses and counts rising edges.
//
// Parameters
//   CNT_W      width of the clkb rising-edge counter (wraps, no saturation)
//
// Ports
//   clka       in   system clock, every flop uses its rising edge
//   rst_n      in   asynchronous active-low reset
//   clkb       in   companion clock, treated as data
//   E          in   decoder enable, active-high
//   In[2:0]    in   decoder select
//   Out[7:0]   out  combinational one-hot decode (zero when E=0)
//   Out_q[7:0] out  Out registered on clka
//   clka_out   out  clka forwarded with no logic in the path
//   clkb_out   out  clkb sampled on clka
//   clkb_rise  out  one-cycle pulse when the sampled clkb goes 0->1
//   clkb_fall  out  one-cycle pulse when the sampled clkb goes 1->0
//   clkb_cnt   out  number of clkb rising edges seen, modulo 2**CNT_W
// ---------------------------------------------------------------------------
module clkgen_decoder_3_8 #(
    parameter int CNT_W = 8
) (
    input  logic             clka,
    input  logic             rst_n,
    input  logic             clkb,
    input  logic             E,
    input  logic [2:0]       In,
    output logic [7:0]       Out,
    output logic [7:0]       Out_q,
    output logic             clka_out,
    output logic             clkb_out,
    output logic             clkb_rise,
    output logic             clkb_fall,
    output logic [CNT_W-1:0] clkb_cnt
);

    logic [7:0]       out_q_q;
    logic             clkb_q;
    logic             clkb_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // ------------------------------------------------------------------
    // Decoder: purely combinational, independent of clock and reset.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: assign a default before any conditional write so no path
        // leaves Out unassigned; otherwise synthesis infers a latch.
        Out = 8'h00;
        if (E) begin
            Out[In] = 1'b1;
        end
    end

    // The forwarded clock is a plain wire so it carries no extra skew.
    // Reset does not gate it.
    assign clka_out = clka;

    // ------------------------------------------------------------------
    // Edge detection on the sampled companion clock. Both pulses come only
    // from flops, so each lasts exactly one clka cycle. The two pulses can
    // never be high together.
    // ------------------------------------------------------------------
    assign clkb_rise = clkb_q & ~clkb_prev_q;
    assign clkb_fall = ~clkb_q & clkb_prev_q;

    // The counter advances in the cycle after the rise pulse is visible.
    // It wraps to zero on overflow.
    always_comb begin
        cnt_d = cnt_q;
        if (clkb_rise) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // A single sampling flop is enough here. clkb only changes away from
    // rising edges of clka, so no synchroniser chain is needed.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            out_q_q     <= 8'h00;
            clkb_q      <= 1'b0;
            clkb_prev_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value of the others. clkb_prev_q therefore gets the
            // old clkb_q, not the value being loaded in this same edge.
            out_q_q     <= Out;
            clkb_q      <= clkb;
            clkb_prev_q <= clkb_q;
            cnt_q       <= cnt_d;
        end
    end

    assign Out_q    = out_q_q;
    assign clkb_out = clkb_q;
    assign clkb_cnt = cnt_q;

endmodule

// File: tb/tb_clkgen_decoder_3_8.sv
// ---------------------------------------------------------------------------
// Testbench for clkgen_decoder_3_8.
//   * Decoder vectors come from a table of {E, In, expected Out} records.
//   * Registered and clock-unit behaviour is predicted by a small
//     cycle model. The model pushes an expectation when stimulus is driven
//     and pops it to compare once the DUT has clocked.
//   * Hand-written sequences cover the counter wrap and an asynchronous
//     reset in the middle of a run.
// clka has period 20 with rising edges at 10, 30, 50, ... . clkb is only
// changed on clka falling edges.
// ---------------------------------------------------------------------------
module tb_clkgen_decoder_3_8;

    localparam int CNT_W = 8;

    logic             clka;
    logic             rst_n;
    logic             clkb;
    logic             E;
    logic [2:0]       In;
    logic [7:0]       Out;
    logic [7:0]       Out_q;
    logic             clka_out;
    logic             clkb_out;
    logic             clkb_rise;
    logic             clkb_fall;
    logic [CNT_W-1:0] clkb_cnt;

    clkgen_decoder_3_8 #(.CNT_W(CNT_W)) dut (
        .clka      (clka),
        .rst_n     (rst_n),
        .clkb      (clkb),
        .E         (E),
        .In        (In),
        .Out       (Out),
        .Out_q     (Out_q),
        .clka_out  (clka_out),
        .clkb_out  (clkb_out),
        .clkb_rise (clkb_rise),
        .clkb_fall (clkb_fall),
        .clkb_cnt  (clkb_cnt)
    );

    initial clka = 1'b0;
    always #10 clka = ~clka;

    // Decoder vector record.
    typedef struct {
        logic       e;
        logic [2:0] in;
        logic [7:0] exp_out;
    } dec_vec_t;

    // Expected state after a clka rising edge.
    typedef struct {
        logic [7:0]       outq;
        logic             samp;
        logic             rise;
        logic             fall;
        logic [CNT_W-1:0] cnt;
    } cyc_exp_t;

    dec_vec_t   vecs[16];
    logic [7:0] dec_sb[$];
    cyc_exp_t   cyc_sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Cycle model state: values visible after the most recent clka edge.
    logic             m_samp, m_prev, m_rise;
    logic [7:0]       m_outq;
    logic [CNT_W-1:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dec_ref(input logic e, input logic [2:0] in);
        case ({e, in})
            4'b1000: dec_ref = 8'h01;
            4'b1001: dec_ref = 8'h02;
            4'b1010: dec_ref = 8'h04;
            4'b1011: dec_ref = 8'h08;
            4'b1100: dec_ref = 8'h10;
            4'b1101: dec_ref = 8'h20;
            4'b1110: dec_ref = 8'h40;
            4'b1111: dec_ref = 8'h80;
            default: dec_ref = 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_samp = 1'b0;
        m_prev = 1'b0;
        m_rise = 1'b0;
        m_outq = 8'h00;
        m_cnt  = '0;
    endtask

    // Run one clka cycle. Drive clkb/E/In at the falling edge, predict the
    // state after the next rising edge, then compare once that edge is done.
    task automatic cycle(input logic clkb_v, input logic e_v, input logic [2:0] in_v);
        cyc_exp_t x;
        cyc_exp_t got;
        @(negedge clka);
        clkb = clkb_v;
        E    = e_v;
        In   = in_v;
        if (m_rise) m_cnt = m_cnt + 1'b1;
        m_outq = dec_ref(e_v, in_v);
        m_prev = m_samp;
        m_samp = clkb_v;
        m_rise = m_samp & ~m_prev;
        x.outq = m_outq;
        x.samp = m_samp;
        x.rise = m_rise;
        x.fall = ~m_samp & m_prev;
        x.cnt  = m_cnt;
        cyc_sb.push_back(x);
        @(posedge clka);
        #1;
        if (cyc_sb.size() == 0) begin
            check("cycle scoreboard empty", 32'd0, 32'd1);
        end else begin
            got = cyc_sb.pop_front();
            check("Out_q",     {24'd0, Out_q},    {24'd0, got.outq});
            check("clkb_out",  {31'd0, clkb_out}, {31'd0, got.samp});
            check("clkb_rise", {31'd0, clkb_rise}, {31'd0, got.rise});
            check("clkb_fall", {31'd0, clkb_fall}, {31'd0, got.fall});
            check("clkb_cnt",  {24'd0, clkb_cnt}, {24'd0, got.cnt});
            check("clka_out high", {31'd0, clka_out}, 32'd1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_v;

        for (int i = 0; i < 8; i++) begin
            vecs[i].e           = 1'b0;
            vecs[i].in          = 3'(i);
            vecs[i].exp_out     = 8'h00;
            vecs[i + 8].e       = 1'b1;
            vecs[i + 8].in      = 3'(i);
            vecs[i + 8].exp_out = 8'h01 << i;
        end

        rst_n = 1'b1;
        clkb  = 1'b0;
        E     = 1'b0;
        In    = 3'd0;
        model_reset();
        #3 rst_n = 1'b0;

        // Reset state, sampled after a clka edge while reset is held.
        #22;
        check("reset Out_q",     {24'd0, Out_q},     32'd0);
        check("reset clkb_out",  {31'd0, clkb_out},  32'd0);
        check("reset clkb_rise", {31'd0, clkb_rise}, 32'd0);
        check("reset clkb_fall", {31'd0, clkb_fall}, 32'd0);
        check("reset clkb_cnt",  {24'd0, clkb_cnt},  32'd0);
        @(negedge clka);
        rst_n = 1'b1;

        // Combinational decoder: table sweep, one step every 10 time units.
        for (int i = 0; i < 16; i++) begin
            E  = vecs[i].e;
            In = vecs[i].in;
            dec_sb.push_back(vecs[i].exp_out);
            #5;
            exp_v = dec_sb.pop_front();
            check($sformatf("Out E=%0b In=%0d", vecs[i].e, vecs[i].in), {24'd0, Out}, {24'd0, exp_v});
            check("clka_out tracks clka", {31'd0, clka_out}, {31'd0, clka});
            #5;
        end

        // Registered decode.
        model_reset();
        cycle(1'b0, 1'b1, 3'd5);
        check("Out_q E=1 In=5", {24'd0, Out_q}, 32'h20);
        cycle(1'b0, 1'b0, 3'd5);
        check("Out_q after E=0", {24'd0, Out_q}, 32'h00);

        // Half-rate clkb: it toggles every clka cycle.
        for (int i = 0; i < 8; i++) begin
            cycle(~clkb, 1'b0, 3'd0);
            check("rise/fall exclusive", {31'd0, clkb_rise & clkb_fall}, 32'd0);
        end

        // Counter wrap.
        while (m_cnt != 8'd255) cycle(~clkb, 1'b0, 3'd0);
        check("clkb_cnt at 255", {24'd0, clkb_cnt}, 32'd255);
        while (m_cnt != 8'd0) cycle(~clkb, 1'b0, 3'd0);
        check("clkb_cnt wrapped", {24'd0, clkb_cnt}, 32'd0);

        // Build up count 5 with Out_q=04, then assert reset between edges.
        while (m_cnt != 8'd5) cycle(~clkb, 1'b1, 3'd2);
        check("pre-reset Out_q", {24'd0, Out_q}, 32'h04);
        @(negedge clka);
        #3 rst_n = 1'b0;
        #1;
        check("async rst clkb_cnt",  {24'd0, clkb_cnt},  32'd0);
        check("async rst Out_q",     {24'd0, Out_q},     32'd0);
        check("async rst clkb_out",  {31'd0, clkb_out},  32'd0);
        check("async rst clkb_rise", {31'd0, clkb_rise}, 32'd0);
        check("async rst clkb_fall", {31'd0, clkb_fall}, 32'd0);
        check("Out during reset", {24'd0, Out}, 32'h04);
        In = 3'd6;
        #1;
        check("Out follows In in reset", {24'd0, Out}, 32'h40);
        @(posedge clka);
        #1;
        check("reset held Out_q", {24'd0, Out_q}, 32'd0);
        check("reset held clkb_cnt", {24'd0, clkb_cnt}, 32'd0);

        // Release. The first sample of clkb=1 gives a rise pulse and a count of 1.
        @(negedge clka);
        rst_n = 1'b1;
        model_reset();
        cycle(1'b1, 1'b1, 3'd6);
        check("post-reset rise", {31'd0, clkb_rise}, 32'd1);
        cycle(1'b1, 1'b1, 3'd6);
        check("post-reset count", {24'd0, clkb_cnt}, 32'd1);
        cycle(1'b0, 1'b0, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
